// File: rtl/sanmoku_pkg.sv
// sanmoku_pkg: shared state encoding, board geometry and per-state o/x cell masks
package sanmoku_pkg;
  typedef enum logic [4:0] {
    S0, S1, S2, S3, S4_0, S4_1, S4_2, S4_3, S4_4, S5, S6_0, S6_1,
    S6_2, S7_0, S7_1, S7_2, S7_3, S7_4, S8, S9, S10_0, S10_1, S10_2, S11
  } statetype;
  localparam int NSTATE = 24;
  localparam int NCELL = 9;
  localparam logic [NCELL-1:0] O_MASK [NSTATE] = '{
    9'h010, 9'h011, 9'h050, 9'h019, 9'h111, 9'h111, 9'h111, 9'h111,
    9'h111, 9'h039, 9'h059, 9'h059, 9'h059, 9'h054, 9'h054, 9'h054,
    9'h054, 9'h054, 9'h0D0, 9'h0D0, 9'h0D2, 9'h0D2, 9'h0D2, 9'h000
  };
  localparam logic [NCELL-1:0] X_MASK [NSTATE] = '{
    9'h000, 9'h002, 9'h001, 9'h102, 9'h006, 9'h00A, 9'h022, 9'h042,
    9'h082, 9'h142, 9'h106, 9'h122, 9'h182, 9'h003, 9'h009, 9'h021,
    9'h081, 9'h101, 9'h005, 9'h007, 9'h00D, 9'h025, 9'h105, 9'h000
  };
endpackage

// File: rtl/sanmoku_state_decode.sv
// sanmoku_state_decode: one-hot state s -> valid (exactly one bit), hold (S11), o_mask/x_mask
module sanmoku_state_decode
  import sanmoku_pkg::*;
(
  input  logic [NSTATE-1:0] s,
  output logic              valid,
  output logic              hold,
  output logic [NCELL-1:0]  o_mask,
  output logic [NCELL-1:0]  x_mask
);
  always_comb begin
    o_mask = '0;
    x_mask = '0;
    for (int i = 0; i < NSTATE; i++) begin
      o_mask = o_mask | (s[i] ? O_MASK[i] : '0);
      x_mask = x_mask | (s[i] ? X_MASK[i] : '0);
    end
  end
  assign valid = $onehot(s);
  assign hold = s[S11];
endmodule

// File: rtl/sanmoku_board_display.sv
// sanmoku_board_display: CLK/RST; s,isNotEnd,userWins in; board_o/x, row_n/col_o/col_x scan, led_win/lose blink, sticky err out
module sanmoku_board_display
  import sanmoku_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 25000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [23:0] s,
  input  logic        isNotEnd,
  input  logic        userWins,
  output logic [8:0]  board_o,
  output logic [8:0]  board_x,
  output logic [2:0]  row_n,
  output logic [2:0]  col_o,
  output logic [2:0]  col_x,
  output logic        led_win,
  output logic        led_lose,
  output logic        err
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  logic [23:0] s_q;
  logic v_q, ne_q, ne_d, uw_q, done, res_win, phase;
  logic [SW-1:0] scnt;
  logic [BW-1:0] bcnt;
  logic valid, hold, tc, bt;
  logic [8:0] o_mask, x_mask;
  logic [2:0] row_nx;
  sanmoku_state_decode u_dec (
    .s      (s_q),
    .valid  (valid),
    .hold   (hold),
    .o_mask (o_mask),
    .x_mask (x_mask)
  );
  always_comb begin
    tc = scnt == SW'(SCAN_DIV - 1);
    bt = bcnt == BW'(BLINK_DIV - 1);
    row_nx = tc ? {row_n[1:0], row_n[2]} : row_n;
  end
  // v_q masks the empty stage-1 register right after reset so it is not flagged as illegal.
  // ne_q/ne_d reset to 1 so isNotEnd already low out of reset still forms a falling edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s_q <= '0;
      v_q <= 1'b0;
      ne_q <= 1'b1;
      ne_d <= 1'b1;
      uw_q <= 1'b0;
      board_o <= '0;
      board_x <= '0;
      err <= 1'b0;
      scnt <= '0;
      row_n <= 3'b110;
      col_o <= '0;
      col_x <= '0;
      done <= 1'b0;
      res_win <= 1'b0;
      phase <= 1'b0;
      bcnt <= '0;
    end else begin
      s_q <= s;
      v_q <= 1'b1;
      ne_q <= isNotEnd;
      ne_d <= ne_q;
      uw_q <= userWins;
      if (v_q && valid && !hold) begin
        board_o <= o_mask;
        board_x <= x_mask;
      end
      if (v_q && !valid) err <= 1'b1;
      scnt <= tc ? '0 : scnt + 1'b1;
      row_n <= row_nx;
      col_o <= !row_nx[0] ? board_o[2:0] : !row_nx[1] ? board_o[5:3] : board_o[8:6];
      col_x <= !row_nx[0] ? board_x[2:0] : !row_nx[1] ? board_x[5:3] : board_x[8:6];
      if (!done && ne_d && !ne_q) begin
        done <= 1'b1;
        res_win <= uw_q;
        phase <= 1'b1;
        bcnt <= '0;
      end else if (done) begin
        bcnt <= bt ? '0 : bcnt + 1'b1;
        phase <= phase ^ bt;
      end
    end
  end
  assign led_win = res_win & phase;
  assign led_lose = !res_win & phase;
endmodule

// File: tb/tb_sanmoku_board_display.sv
// tb_sanmoku_board_display: table-driven and directed checks of decode, scan, blink, err and reset
module tb_sanmoku_board_display;
  import sanmoku_pkg::*;
  logic CLK = 1'b0;
  logic RST;
  logic [23:0] s;
  logic isNotEnd, userWins;
  logic [8:0] board_o, board_x;
  logic [2:0] row_n, col_o, col_x;
  logic led_win, led_lose, err;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    statetype st;
    logic [8:0] eo;
    logic [8:0] ex;
  } vec_t;
  vec_t tv [24];
  always #5 CLK = ~CLK;
  sanmoku_board_display #(.SCAN_DIV(4), .BLINK_DIV(8)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .s        (s),
    .isNotEnd (isNotEnd),
    .userWins (userWins),
    .board_o  (board_o),
    .board_x  (board_x),
    .row_n    (row_n),
    .col_o    (col_o),
    .col_x    (col_x),
    .led_win  (led_win),
    .led_lose (led_lose),
    .err      (err)
  );
  function automatic logic [23:0] oh(input statetype st);
    return 24'(1) << st;
  endfunction
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, " board_o"}, 32'(board_o), 32'h0);
    chk({tag, " board_x"}, 32'(board_x), 32'h0);
    chk({tag, " row_n"}, 32'(row_n), 32'h6);
    chk({tag, " col_o"}, 32'(col_o), 32'h0);
    chk({tag, " col_x"}, 32'(col_x), 32'h0);
    chk({tag, " led_win"}, 32'(led_win), 32'h0);
    chk({tag, " led_lose"}, 32'(led_lose), 32'h0);
    chk({tag, " err"}, 32'(err), 32'h0);
  endtask
  initial begin
    tv[0]  = '{S0,    9'h010, 9'h000};
    tv[1]  = '{S1,    9'h011, 9'h002};
    tv[2]  = '{S2,    9'h050, 9'h001};
    tv[3]  = '{S3,    9'h019, 9'h102};
    tv[4]  = '{S4_0,  9'h111, 9'h006};
    tv[5]  = '{S4_1,  9'h111, 9'h00A};
    tv[6]  = '{S4_2,  9'h111, 9'h022};
    tv[7]  = '{S4_3,  9'h111, 9'h042};
    tv[8]  = '{S4_4,  9'h111, 9'h082};
    tv[9]  = '{S5,    9'h039, 9'h142};
    tv[10] = '{S6_0,  9'h059, 9'h106};
    tv[11] = '{S6_1,  9'h059, 9'h122};
    tv[12] = '{S6_2,  9'h059, 9'h182};
    tv[13] = '{S7_0,  9'h054, 9'h003};
    tv[14] = '{S7_1,  9'h054, 9'h009};
    tv[15] = '{S7_2,  9'h054, 9'h021};
    tv[16] = '{S7_3,  9'h054, 9'h081};
    tv[17] = '{S7_4,  9'h054, 9'h101};
    tv[18] = '{S8,    9'h0D0, 9'h005};
    tv[19] = '{S9,    9'h0D0, 9'h007};
    tv[20] = '{S10_0, 9'h0D2, 9'h00D};
    tv[21] = '{S10_1, 9'h0D2, 9'h025};
    tv[22] = '{S10_2, 9'h0D2, 9'h105};
    tv[23] = '{S11,   9'h0D2, 9'h105};
    RST = 1'b1;
    s = oh(S0);
    isNotEnd = 1'b1;
    userWins = 1'b0;
    repeat (3) tick();
    chk_reset_vals("reset");
    RST = 1'b0;
    tick();
    chk("row0 start", 32'(row_n), 32'h6);
    tick();
    chk("S0 board_o", 32'(board_o), 32'h010);
    chk("S0 board_x", 32'(board_x), 32'h000);
    repeat (2) tick();
    chk("row1 row_n", 32'(row_n), 32'h5);
    chk("S0 row1 col_o", 32'(col_o), 32'h2);
    chk("S0 row1 col_x", 32'(col_x), 32'h0);
    s = oh(S4_2);
    repeat (2) tick();
    chk("S4_2 board_o", 32'(board_o), 32'h111);
    chk("S4_2 board_x", 32'(board_x), 32'h022);
    tick();
    chk("S4_2 row_n still 1", 32'(row_n), 32'h5);
    chk("S4_2 row1 col_o", 32'(col_o), 32'h2);
    chk("S4_2 row1 col_x", 32'(col_x), 32'h4);
    tick();
    chk("row2 row_n", 32'(row_n), 32'h3);
    chk("S4_2 row2 col_o", 32'(col_o), 32'h4);
    chk("S4_2 row2 col_x", 32'(col_x), 32'h0);
    repeat (4) tick();
    chk("row wrap row_n", 32'(row_n), 32'h6);
    chk("S4_2 row0 col_o", 32'(col_o), 32'h1);
    chk("S4_2 row0 col_x", 32'(col_x), 32'h2);
    for (int i = 0; i < 24; i++) begin
      s = oh(tv[i].st);
      repeat (2) tick();
      chk($sformatf("tbl%0d board_o", i), 32'(board_o), 32'(tv[i].eo));
      chk($sformatf("tbl%0d board_x", i), 32'(board_x), 32'(tv[i].ex));
      chk($sformatf("tbl%0d err", i), 32'(err), 32'h0);
    end
    RST = 1'b1;
    s = oh(S1);
    tick();
    RST = 1'b0;
    repeat (2) tick();
    chk("S1 board_o", 32'(board_o), 32'h011);
    chk("S1 err", 32'(err), 32'h0);
    s = 24'h000003;
    repeat (2) tick();
    chk("illegal err", 32'(err), 32'h1);
    chk("illegal hold o", 32'(board_o), 32'h011);
    chk("illegal hold x", 32'(board_x), 32'h002);
    s = oh(S2);
    repeat (2) tick();
    chk("S2 after err board_o", 32'(board_o), 32'h050);
    chk("S2 after err board_x", 32'(board_x), 32'h001);
    chk("err sticky", 32'(err), 32'h1);
    s = 24'h0;
    repeat (2) tick();
    chk("zero-hot hold o", 32'(board_o), 32'h050);
    RST = 1'b1;
    s = oh(S9);
    isNotEnd = 1'b1;
    userWins = 1'b0;
    tick();
    RST = 1'b0;
    repeat (2) tick();
    isNotEnd = 1'b0;
    tick();
    chk("lose pre-latch", 32'(led_lose), 32'h0);
    for (int k = 0; k < 17; k++) begin
      tick();
      chk($sformatf("lose blink k%0d", k), 32'(led_lose), (k < 8 || k == 16) ? 32'h1 : 32'h0);
      chk($sformatf("lose win k%0d", k), 32'(led_win), 32'h0);
    end
    s = oh(S11);
    repeat (2) tick();
    chk("S11 hold o", 32'(board_o), 32'h0D0);
    chk("S11 hold x", 32'(board_x), 32'h007);
    userWins = 1'b1;
    isNotEnd = 1'b1;
    repeat (2) tick();
    isNotEnd = 1'b0;
    repeat (20) tick();
    chk("later edge ignored win", 32'(led_win), 32'h0);
    RST = 1'b1;
    s = oh(S0);
    isNotEnd = 1'b0;
    userWins = 1'b1;
    repeat (2) tick();
    RST = 1'b0;
    tick();
    chk("win from reset E1", 32'(led_win), 32'h0);
    tick();
    chk("win from reset E2", 32'(led_win), 32'h1);
    chk("win from reset lose", 32'(led_lose), 32'h0);
    repeat (6) tick();
    chk("mid-blink row2", 32'(row_n), 32'h3);
    chk("mid-blink win", 32'(led_win), 32'h1);
    chk("mid-blink board", 32'(board_o), 32'h010);
    RST = 1'b1;
    tick();
    chk_reset_vals("midreset");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
